// File: rtl/rv_rf_mp_if.sv
// Decode-stage register file bundle: Q101H read/decode, Q102H operand stage, Q104H write-back.
// master = decode/pipeline side, slave = register file.
interface rv_rf_mp_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0]   rd_addr_Q101H;
  logic [NUM_RD-1:0]      rd_vld_Q101H;
  logic                   vld_Q101H;
  logic                   ready_Q102H;
  logic                   flush_Q102H;
  logic [NUM_WR-1:0]      wr_en_Q104H;
  logic [NUM_WR*AW-1:0]   wr_addr_Q104H;
  logic [NUM_WR*XLEN-1:0] wr_data_Q104H;
  logic                   alloc_en_Q101H;
  logic [AW-1:0]          alloc_addr_Q101H;
  logic                   sb_clr;
  logic                   stall_Q101H;
  logic [NUM_RD*XLEN-1:0] rd_data_Q102H;
  logic                   vld_Q102H;

  // Q102H advances only when ready_Q102H=1; flush_Q102H kills the entering slot even while held.
  modport master (
    output rd_addr_Q101H, rd_vld_Q101H, vld_Q101H, ready_Q102H, flush_Q102H,
           wr_en_Q104H, wr_addr_Q104H, wr_data_Q104H,
           alloc_en_Q101H, alloc_addr_Q101H, sb_clr,
    input  stall_Q101H, rd_data_Q102H, vld_Q102H
  );

  modport slave (
    input  rd_addr_Q101H, rd_vld_Q101H, vld_Q101H, ready_Q102H, flush_Q102H,
           wr_en_Q104H, wr_addr_Q104H, wr_data_Q104H,
           alloc_en_Q101H, alloc_addr_Q101H, sb_clr,
    output stall_Q101H, rd_data_Q102H, vld_Q102H
  );
endinterface

// File: rtl/rv_rf_mp.sv
// Multi-port register file with same-cycle write-back bypass and a Q102H operand register.
// Define RV_RF_SCOREBOARD_EN to add per-register busy bits and a RAW decode stall.
module rv_rf_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
) (
  input logic         clk,
  input logic         rst,
  rv_rf_mp_if.slave   rf_if
);
  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0] rf [NUM_REGS];

  logic [AW-1:0]   rd_addr [NUM_RD];
  logic [AW-1:0]   wr_addr [NUM_WR];
  logic [XLEN-1:0] wr_data [NUM_WR];
  logic [XLEN-1:0] rd_res  [NUM_RD];
  logic [NUM_RD-1:0]      wb_hit;
  logic [NUM_RD*XLEN-1:0] rd_res_flat;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_addr[i] = rf_if.rd_addr_Q101H[i*AW +: AW];
    assign rd_res_flat[i*XLEN +: XLEN] = rd_res[i];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wr_addr[j] = rf_if.wr_addr_Q104H[j*AW +: AW];
    assign wr_data[j] = rf_if.wr_data_Q104H[j*XLEN +: XLEN];
  end

  // Ascending scan so the highest matching write port supplies the bypass value.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_res[i] = rf[rd_addr[i]];
      wb_hit[i] = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (rf_if.wr_en_Q104H[j] && (wr_addr[j] == rd_addr[i])) begin
          rd_res[i] = wr_data[j];
          wb_hit[i] = 1'b1;
        end
      end
      if (rd_addr[i] == '0) begin
        rd_res[i] = '0;
        wb_hit[i] = 1'b0;
      end
    end
  end

  // Later non-blocking writes override earlier ones: highest port wins on collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (rf_if.wr_en_Q104H[j] && (wr_addr[j] != '0)) rf[wr_addr[j]] <= wr_data[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_if.rd_data_Q102H <= '0;
      rf_if.vld_Q102H     <= 1'b0;
    end else if (rf_if.ready_Q102H) begin
      rf_if.rd_data_Q102H <= rd_res_flat;
      rf_if.vld_Q102H     <= rf_if.vld_Q101H & ~rf_if.stall_Q101H & ~rf_if.flush_Q102H;
    end else if (rf_if.flush_Q102H) begin
      rf_if.vld_Q102H     <= 1'b0;
    end
  end

`ifdef RV_RF_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy;
  logic                alloc_fire;
  logic                stall_raw;

  assign alloc_fire = rf_if.alloc_en_Q101H & rf_if.vld_Q101H & rf_if.ready_Q102H &
                      ~rf_if.stall_Q101H & ~rf_if.flush_Q102H;

  // Set is applied after the clears so a new producer wins over a retiring one.
  always_ff @(posedge clk) begin
    if (rst || rf_if.sb_clr) begin
      busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (rf_if.wr_en_Q104H[j]) busy[wr_addr[j]] <= 1'b0;
      end
      if (alloc_fire && (rf_if.alloc_addr_Q101H != '0)) busy[rf_if.alloc_addr_Q101H] <= 1'b1;
    end
  end

  // A write-back landing this cycle resolves the hazard through the bypass.
  always_comb begin
    stall_raw = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rf_if.rd_vld_Q101H[i] && busy[rd_addr[i]] && !wb_hit[i]) stall_raw = 1'b1;
    end
  end

  assign rf_if.stall_Q101H = rf_if.vld_Q101H & stall_raw;
`else
  logic unused_sb;
  assign unused_sb = ^{rf_if.alloc_en_Q101H, rf_if.alloc_addr_Q101H, rf_if.sb_clr,
                       rf_if.rd_vld_Q101H, wb_hit};
  assign rf_if.stall_Q101H = 1'b0;
`endif

endmodule
